// File: rtl/mux_arbiter_pkg.sv
// Shared constants for the two-requester mux arbiter family.
// State encodings stay plain 2-bit constants so older arbiters can share them.
package mux_arbiter_pkg;

  localparam logic [1:0] STATE_IDLE = 2'b00;
  localparam logic [1:0] STATE_OWN0 = 2'b01;
  localparam logic [1:0] STATE_OWN1 = 2'b10;

  localparam int MAX_HOLD_DEFAULT = 8;
  localparam int CNT_W_DEFAULT    = 8;

endpackage

// File: rtl/mux_arbiter_tenure_counter.sv
// Saturating tenure counter: clears on request, otherwise counts up to limit and holds.
module tenure_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         atLimit
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign atLimit = (r_count == limit);

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of the shared 2:1 mux; all outputs registered.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] grant,
  output logic       sel,
  output logic       busy,
  output logic       preempt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

  logic [1:0] r_state;
  logic       r_last;
  logic [1:0] r_grant;
  logic       r_sel;
  logic       r_busy;
  logic       r_preempt;

  logic [1:0] w_nextState;
  logic       w_nextLast;
  logic       w_preempt;
  logic       w_owner;
  logic       w_peer;
  logic       w_timeout;
  logic       w_release;
  logic       w_atLimit;
  logic       w_clear;

  // Counter restarts on every new tenure and is held at zero while idle.
  assign w_clear = (w_nextState != r_state) || (r_state == STATE_IDLE);

  tenure_counter #(
    .W(CNT_W)
  ) u_tenure (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_clear),
    .limit  (LIMIT),
    .atLimit(w_atLimit)
  );

  assign w_owner   = (r_state == STATE_OWN1);
  assign w_peer    = ~w_owner;
  assign w_timeout = w_atLimit && req[w_peer];
  assign w_release = done[w_owner] || !req[w_owner] || w_timeout;

  always_comb begin
    w_nextState = r_state;
    w_nextLast  = r_last;
    w_preempt   = 1'b0;
    case (r_state)
      STATE_IDLE: begin
        case (req)
          2'b01:   w_nextState = STATE_OWN0;
          2'b10:   w_nextState = STATE_OWN1;
          2'b11:   w_nextState = r_last ? STATE_OWN0 : STATE_OWN1;
          default: w_nextState = STATE_IDLE;
        endcase
      end
      STATE_OWN0, STATE_OWN1: begin
        if (w_release) begin
          w_nextLast = w_owner;
          // Hand straight to a waiting peer so the mux never sees an idle bubble.
          if (req[w_peer]) begin
            w_nextState = w_owner ? STATE_OWN0 : STATE_OWN1;
          end else begin
            w_nextState = STATE_IDLE;
          end
          w_preempt = w_timeout && !done[w_owner] && req[w_owner];
        end
      end
      default: w_nextState = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= STATE_IDLE;
      r_last    <= 1'b1;
      r_grant   <= 2'b00;
      r_sel     <= 1'b0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_last    <= w_nextLast;
      r_grant   <= {w_nextState == STATE_OWN1, w_nextState == STATE_OWN0};
      r_busy    <= (w_nextState != STATE_IDLE);
      r_preempt <= w_preempt;
      // Select only moves on a grant edge; it parks on the last owner when idle.
      if (w_nextState == STATE_OWN0) begin
        r_sel <= 1'b0;
      end else if (w_nextState == STATE_OWN1) begin
        r_sel <= 1'b1;
      end
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter with MAX_HOLD=4.
module tb_mux_arbiter;

  logic       clk;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] grant;
  logic       sel;
  logic       busy;
  logic       preempt;

  int passCount  = 0;
  int checkCount = 0;

  mux_arbiter #(
    .MAX_HOLD(4),
    .CNT_W   (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .sel    (sel),
    .busy   (busy),
    .preempt(preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, then let one rising edge pass and settle 1ns after it.
  task automatic applyStimulus(input logic rstN, input logic [1:0] reqV, input logic [1:0] doneV);
    reset_n = rstN;
    req     = reqV;
    done    = doneV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] expGrant, input logic expSel,
                             input logic expBusy, input logic expPreempt);
    logic [4:0] observed;
    logic [4:0] expected;
    observed = {grant, sel, busy, preempt};
    expected = {expGrant, expSel, expBusy, expPreempt};
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      $error("[TB] FAIL %s: {grant,sel,busy,preempt} got %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0] expG;
    logic       expP;
    reset_n = 1'b0;
    req     = 2'b00;
    done    = 2'b00;

    applyStimulus(1'b0, 2'b00, 2'b00);
    checkOutput("reset", 2'b00, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 2'b01, 2'b00);
    checkOutput("grant0", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b01, 2'b01);
    checkOutput("done0", 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 2'b00);
    checkOutput("idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Continuous contention: four cycles each, preempt on every switch.
    applyStimulus(1'b0, 2'b00, 2'b00);
    checkOutput("reset2", 2'b00, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b1, 2'b11, 2'b00);
      expG = (((e - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      expP = (e > 1) && ((e - 1) % 4 == 0);
      checkOutput($sformatf("contend%0d", e), expG, expG[1], 1'b1, expP);
    end

    // Owner 0 drops request at saturation: handover without preempt.
    applyStimulus(1'b1, 2'b10, 2'b00);
    checkOutput("drop0", 2'b10, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 2'b10, 2'b00);
      checkOutput($sformatf("hold1_%0d", c), 2'b10, 1'b1, 1'b1, 1'b0);
    end

    // done wins over a coincident timeout, so no preempt.
    applyStimulus(1'b1, 2'b11, 2'b10);
    checkOutput("done1handover", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b11, 2'b00);
    checkOutput("own0a", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b11, 2'b10);
    checkOutput("foreignDone", 2'b01, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b11, 2'b01);
    checkOutput("done0handover", 2'b10, 1'b1, 1'b1, 1'b0);

    applyStimulus(1'b1, 2'b11, 2'b00);
    checkOutput("own1mid", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b11, 2'b00);
    checkOutput("midReset", 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 2'b00);
    checkOutput("postResetTie", 2'b01, 1'b0, 1'b1, 1'b0);

    // sel parks on the last owner once idle.
    applyStimulus(1'b1, 2'b00, 2'b00);
    checkOutput("release0", 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'b00);
    checkOutput("grant1", 2'b10, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 2'b00);
    checkOutput("selHold", 2'b00, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
